// File: rtl/booth_ctrl.sv
// booth_ctrl
// Sequencing controller for a radix-2 Booth multiplier datapath. It walks
// the accumulator (A) and multiplier (Q) registers through one load cycle
// followed by WIDTH evaluate/shift pairs, then pulses done for one cycle
// while the product sits in {A,Q}.
//
// Ports:
//   clock       rising-edge clock
//   _reset      asynchronous active-low reset
//   start       multiply request, only looked at while idle
//   q0          current LSB of the Q register
//   a_msb       current MSB (sign) of the A register
//   a_sel       A register mode {s1,s0}: 00 hold, 01 load, 10 shift, 11 ashift
//   q_sel       Q register mode, same encoding as a_sel
//   a_shift_in  serial input into A while shifting (sign replication)
//   m_load      load the multiplicand register
//   alu_op      00 pass A, 01 A+M, 10 A-M, 11 zero
//   busy        high from LOAD through the final SHIFT
//   done        one-cycle completion pulse

module booth_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic       clock,
   input  logic       _reset,
   input  logic       start,
   input  logic       q0,
   input  logic       a_msb,
   output logic [1:0] a_sel,
   output logic [1:0] q_sel,
   output logic       a_shift_in,
   output logic       m_load,
   output logic [1:0] alu_op,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      EVAL  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic             qm1;
   logic [CNT_W-1:0] cnt;

   // State sequencing plus the Booth bookkeeping. qm1 is the Q bit that was
   // shifted out on the previous iteration; it must capture q0 before the
   // shift lands, which happens naturally because the Q register updates on
   // the same edge. The counter is checked against one rather than zero so
   // the last SHIFT goes straight to DONE and cnt never wraps.
   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         state <= IDLE;
         qm1   <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               qm1   <= 1'b0;
               cnt   <= CNT_INIT;
               state <= EVAL;
            end
            EVAL: begin
               state <= SHIFT;
            end
            SHIFT: begin
               qm1 <= q0;
               cnt <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state <= DONE;
               end else begin
                  state <= EVAL;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Datapath controls are decoded straight from the state register so that
   // an asynchronous reset, which forces IDLE, drops every control at once.
   // In EVAL the pair {q0,qm1} picks subtract (10), add (01) or hold; in
   // SHIFT both registers shift right with A's sign bit fed back into itself.
   always_comb begin
      a_sel      = 2'b00;
      q_sel      = 2'b00;
      a_shift_in = 1'b0;
      m_load     = 1'b0;
      alu_op     = 2'b00;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         LOAD: begin
            m_load = 1'b1;
            q_sel  = 2'b01;
            a_sel  = 2'b01;
            alu_op = 2'b11;
            busy   = 1'b1;
         end
         EVAL: begin
            busy = 1'b1;
            case ({q0, qm1})
               2'b10: begin
                  a_sel  = 2'b01;
                  alu_op = 2'b10;
               end
               2'b01: begin
                  a_sel  = 2'b01;
                  alu_op = 2'b01;
               end
               default: begin
                  a_sel  = 2'b00;
                  alu_op = 2'b00;
               end
            endcase
         end
         SHIFT: begin
            a_sel      = 2'b10;
            q_sel      = 2'b10;
            a_shift_in = a_msb;
            busy       = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            a_sel = 2'b00;
         end
      endcase
   end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl
// Drives booth_ctrl together with a small reference Booth datapath (A kept
// one bit wider than the operands so that subtracting -2^(WIDTH-1) cannot
// overflow) and checks the controls against a schedule-based model every
// cycle, plus directed products, latencies and handshake checks.

module tb_booth_ctrl;

   localparam int WIDTH = 8;
   localparam int LAST  = 2 * WIDTH + 1;

   logic       clock  = 1'b0;
   logic       _reset = 1'b0;
   logic       start  = 1'b1;
   logic       q0;
   logic       a_msb;
   logic [1:0] a_sel;
   logic [1:0] q_sel;
   logic       a_shift_in;
   logic       m_load;
   logic [1:0] alu_op;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   booth_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
      .clock      (clock),
      ._reset     (_reset),
      .start      (start),
      .q0         (q0),
      .a_msb      (a_msb),
      .a_sel      (a_sel),
      .q_sel      (q_sel),
      .a_shift_in (a_shift_in),
      .m_load     (m_load),
      .alu_op     (alu_op),
      .busy       (busy),
      .done       (done)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Reference datapath: multiplicand M, accumulator A, multiplier Q,
   // steered only by the controller's selects.
   logic [WIDTH:0]   regA = '0;
   logic [WIDTH-1:0] regQ = '0;
   logic [WIDTH:0]   regM = '0;
   logic [WIDTH-1:0] mIn  = '0;
   logic [WIDTH-1:0] qIn  = '0;
   logic [WIDTH:0]   aluOut;

   always_comb begin
      case (alu_op)
         2'b00:   aluOut = regA;
         2'b01:   aluOut = regA + regM;
         2'b10:   aluOut = regA - regM;
         default: aluOut = '0;
      endcase
   end

   always @(posedge clock) begin
      if (m_load) regM <= {mIn[WIDTH-1], mIn};
      case (a_sel)
         2'b01:        regA <= aluOut;
         2'b10, 2'b11: regA <= {a_shift_in, regA[WIDTH:1]};
         default:      regA <= regA;
      endcase
      case (q_sel)
         2'b01:        regQ <= qIn;
         2'b10, 2'b11: regQ <= {regA[0], regQ[WIDTH-1:1]};
         default:      regQ <= regQ;
      endcase
   end

   assign q0    = regQ[0];
   assign a_msb = regA[WIDTH];

   logic [9:0] outVec;
   assign outVec = {a_sel, q_sel, a_shift_in, m_load, alu_op, busy, done};

   // Behavioural model: once a start is accepted, step 0 is the load, odd
   // steps evaluate, even steps 2..2W shift, and step 2W+1 reports done.
   bit mActive = 1'b0;
   int mStep   = 0;
   bit mQm1    = 1'b0;

   always @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         mActive <= 1'b0;
         mQm1    <= 1'b0;
      end else if (!mActive) begin
         if (start) begin
            mActive <= 1'b1;
            mStep   <= 0;
         end
      end else begin
         if (mStep == 0) mQm1 <= 1'b0;
         else if (mStep % 2 == 0) mQm1 <= q0;
         if (mStep == LAST) mActive <= 1'b0;
         else mStep <= mStep + 1;
      end
   end

   function automatic logic [9:0] expOut();
      logic [9:0] e;
      e = '0;
      if (_reset && mActive) begin
         if (mStep == 0) e = {2'b01, 2'b01, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
         else if (mStep == LAST) e = 10'b00_00_0_0_00_0_1;
         else if (mStep % 2 == 1) begin
            if (q0 && !mQm1) e = {2'b01, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0};
            else if (!q0 && mQm1) e = {2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
            else e = 10'b00_00_0_0_00_1_0;
         end else e = {2'b10, 2'b10, a_msb, 1'b0, 2'b00, 1'b1, 1'b0};
      end
      return e;
   endfunction

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      logic [9:0] want;
      want = expOut();
      total++;
      if (outVec !== want) begin
         bad++;
         $display("[TB] FAIL cycleModel t=%0t got=%b want=%b", $time, outVec, want);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Launch one multiply, count cycles from acceptance to done, check product
   // and that done lasts exactly one cycle.
   task automatic applyStimulus(input logic [WIDTH-1:0] mc, input logic [WIDTH-1:0] mp,
                                input logic [15:0] prod, input string name, input bit traceFirst);
      int n;
      bit gotDone;
      mIn = mc;
      qIn = mp;
      start = 1'b1;
      @(posedge clock);
      #2 start = 1'b0;
      n = 1;
      gotDone = 1'b0;
      while (n <= 40 && !gotDone) begin
         @(negedge clock);
         if (traceFirst) begin
            if (n == 1) checkOutput({name, "LoadSel"}, {m_load, a_sel, q_sel, alu_op}, 7'b1_01_01_11);
            if (n == 2) checkOutput({name, "Eval1Alu"}, alu_op, 2'b10);
            if (n == 4) checkOutput({name, "Eval2Alu"}, alu_op, 2'b01);
         end
         if (done === 1'b1) gotDone = 1'b1;
         else n++;
      end
      checkOutput({name, "Latency"}, n, 18);
      checkOutput({name, "Product"}, {regA[WIDTH-1:0], regQ}, prod);
      @(negedge clock);
      checkOutput({name, "DonePulse"}, done, 1'b0);
   endtask

   task automatic countDone(input int cycles, output int dn);
      dn = 0;
      repeat (cycles) begin
         @(negedge clock);
         if (done === 1'b1) dn++;
      end
   endtask

   initial begin
      int n;
      int dn;

      // Reset held with start high: controls must stay quiet.
      repeat (3) begin
         @(negedge clock);
         checkOutput("resetHold", outVec, 10'd0);
      end
      @(posedge clock);
      #2 _reset = 1'b1;

      applyStimulus(8'd3, 8'h05, 16'h000F, "mul3x5", 1'b1);
      applyStimulus(8'hFD, 8'h05, 16'hFFF1, "mulN3x5", 1'b0);
      applyStimulus(8'h80, 8'h80, 16'h4000, "mulN128", 1'b0);
      applyStimulus(8'h00, 8'h7F, 16'h0000, "mul0x7F", 1'b0);

      // Start pulses during EVAL, SHIFT and DONE are ignored.
      mIn = 8'd7;
      qIn = 8'hFE;
      start = 1'b1;
      @(posedge clock);
      #2 start = 1'b0;
      @(posedge clock);
      #2 start = 1'b1;
      @(posedge clock);
      #2 start = 1'b1;
      @(posedge clock);
      #2 start = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (done !== 1'b1 && n < 40);
      checkOutput("pulseLatency", n, 15);
      checkOutput("pulseProduct", {regA[WIDTH-1:0], regQ}, 16'hFFF2);
      start = 1'b1;
      @(posedge clock);
      #2 start = 1'b0;
      countDone(25, dn);
      checkOutput("pulseNoSecondDone", dn, 0);

      // Start held high: back-to-back multiplies.
      mIn = 8'h12;
      qIn = 8'h0A;
      start = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (done !== 1'b1 && n < 40);
      checkOutput("heldProduct1", {regA[WIDTH-1:0], regQ}, 16'h00B4);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (done !== 1'b1 && n < 40);
      checkOutput("heldSpacing", n, 19);
      checkOutput("heldProduct2", {regA[WIDTH-1:0], regQ}, 16'h00B4);
      @(posedge clock);
      #2 start = 1'b0;
      @(negedge clock);

      // Reset pulse during the fourth SHIFT.
      mIn = 8'd3;
      qIn = 8'h55;
      start = 1'b1;
      @(posedge clock);
      #2 start = 1'b0;
      repeat (8) @(posedge clock);
      #3;
      checkOutput("shift4Sel", {busy, a_sel, q_sel}, 5'b1_10_10);
      _reset = 1'b0;
      #1;
      checkOutput("resetDrop", outVec, 10'd0);
      @(posedge clock);
      #2 _reset = 1'b1;
      countDone(25, dn);
      checkOutput("resetNoDone", dn, 0);
      applyStimulus(8'h7F, 8'h7F, 16'h3F01, "mul127", 1'b0);

      #20;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/booth_ctrl.md
Name: booth_ctrl

Overview:
- Sequencing controller for the radix-2 Booth multiplier datapath.
- Sits directly upstream of the multi-function registers (accumulator A, multiplier Q) and drives their 2-bit mode selects (00 hold, 01 load, 10 shift right, 11 arithmetic shift) plus the add/sub ALU and multiplicand load.
- Tracks the Booth Q-1 bit and iteration count internally, and reports completion with a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits; number of Booth iterations.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock
- _reset  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- q0  input  1  current LSB of the Q register (bit 0 of its parallel output)
- a_msb  input  1  current MSB of the A register (sign bit)
- a_sel  output  2  mode select {s1,s0} for the A register
- q_sel  output  2  mode select {s1,s0} for the Q register
- a_shift_in  output  1  serial input for A during shift (= a_msb, arithmetic)
- m_load  output  1  load the multiplicand register
- alu_op  output  2  00 pass A, 01 A+M, 10 A-M, 11 zero
- busy  output  1  high from LOAD through SHIFT of the last iteration
- done  output  1  one-cycle pulse; product valid in {A,Q}

Behaviour:
- States: IDLE, LOAD, EVAL, SHIFT, DONE. Binary encoded state register, reset to IDLE asynchronously on _reset low.
- Outputs are decoded combinationally from state, q0 and qm1.
  - In IDLE, and whenever _reset is low: a_sel=00, q_sel=00, m_load=0, alu_op=00, busy=0, done=0, a_shift_in=0.
  - In IDLE, qm1=0 and cnt=0 only after reset; they hold their last values otherwise.
- IDLE: start=1 -> LOAD. start=0 -> stay.
- LOAD (1 cycle):
  - m_load=1, q_sel=01 (multiplier in), a_sel=01 with alu_op=11 (A cleared), busy=1.
  - On exit: qm1<=0, cnt<=WIDTH. Next state EVAL.
- EVAL (1 cycle), busy=1, decided by {q0,qm1}:
  - 10: a_sel=01, alu_op=10 (A<=A-M).
  - 01: a_sel=01, alu_op=01 (A<=A+M).
  - 00 or 11: a_sel=00, alu_op=00 (hold).
  - q_sel=00 in all cases. Next state SHIFT.
- SHIFT (1 cycle), busy=1:
  - a_sel=10, q_sel=10, a_shift_in=a_msb. Datapath routes A[0] into Q's shift_in.
  - On exit: qm1<=q0 (pre-shift value); cnt<=cnt-1.
  - If cnt==1 -> DONE, else EVAL.
- DONE (1 cycle): done=1, busy=0, all selects 00. Next state IDLE unconditionally.
- start is ignored in LOAD/EVAL/SHIFT/DONE. No queuing. A start held high is re-accepted on the first IDLE cycle after DONE.
- Latency, with start sampled high at edge k:
  - LOAD in cycle k..k+1.
  - WIDTH EVAL/SHIFT pairs follow.
  - done high in the cycle after edge k+2*WIDTH+1, i.e. 2*WIDTH+2 cycles after acceptance (18 for WIDTH=8).
- Reset mid-operation: immediate return to IDLE. All outputs drop to their IDLE values asynchronously. No done pulse. Datapath contents are undefined and not required to be preserved.
- cnt never underflows: SHIFT with cnt==1 always exits to DONE.

Test Plan:
- Reset: hold _reset=0 for 3 cycles with start=1 -> all outputs 0 and state IDLE throughout; first start after release accepted and done seen 18 cycles later.
- Multiplier 0x05 (M=3): start -> LOAD shows m_load=1, a_sel=01, q_sel=01, alu_op=11. First EVAL shows {q0,qm1}=10 -> alu_op=10. Second EVAL {0,1} -> alu_op=01. With reference datapath the product is 16'h000F.
- Signed cases with datapath: -3 x 5 -> 16'hFFF1; -128 x -128 -> 16'h4000; 0 x 0x7F -> 16'h0000; done pulse exactly 1 cycle each.
- start pulsed again during EVAL, SHIFT, and DONE -> ignored; busy/done timing unchanged; no second done.
- start held high continuously -> back-to-back multiplies; done pulses spaced 2*WIDTH+3 = 19 cycles apart.
- Assert _reset low for 1 cycle during the 4th SHIFT -> outputs 0 immediately; no done; a fresh start afterwards completes normally.
